// File: rtl/ring_chaser.sv
// Rotating single-bit pattern generator with a synchronous prescaler enable.
// Build option RING_CHASER_BOUNCE_EN adds the bounce direction register; otherwise mode 10 rotates up.
module ring_chaser #(
    parameter int WIDTH      = 6,
    parameter int PRESC_BITS = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             fast,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] ring,
    output logic             step,
    output logic             dir
);

    localparam logic [1:0] MODE_UP     = 2'b00;
    localparam logic [1:0] MODE_DOWN   = 2'b01;
    localparam logic [1:0] MODE_BOUNCE = 2'b10;
    localparam logic [1:0] MODE_HOLD   = 2'b11;

    localparam logic [WIDTH-1:0] SEED = {1'b1, {(WIDTH-1){1'b0}}};

    logic [PRESC_BITS-1:0] count;
    logic                  tick;
    logic [WIDTH-1:0]      rot_up;
    logic [WIDTH-1:0]      rot_dn;
    logic [WIDTH-1:0]      bounce_nxt;
    logic [WIDTH-1:0]      ring_nxt;

    // Tick is an enable, never a derived clock; fast bypasses the terminal count.
    assign tick   = fast | (&count);
    assign rot_up = {ring[WIDTH-2:0], ring[WIDTH-1]};
    assign rot_dn = {ring[0], ring[WIDTH-1:1]};

`ifdef RING_CHASER_BOUNCE_EN
    logic dir_q;
    logic turn;

    // At an end bit the direction flips and the reversed rotation applies on the same edge.
    assign turn       = dir_q ? ring[0] : ring[WIDTH-1];
    assign bounce_nxt = (dir_q ^ turn) ? rot_dn : rot_up;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_q <= 1'b0;
        end else if (load) begin
            dir_q <= 1'b0;
        end else if (tick && (mode == MODE_BOUNCE) && turn) begin
            dir_q <= ~dir_q;
        end
    end

    assign dir = dir_q;
`else
    assign bounce_nxt = rot_up;
    assign dir        = 1'b0;
`endif

    always_comb begin
        ring_nxt = ring;
        case (mode)
            MODE_UP:     ring_nxt = rot_up;
            MODE_DOWN:   ring_nxt = rot_dn;
            MODE_BOUNCE: ring_nxt = bounce_nxt;
            MODE_HOLD:   ring_nxt = ring;
            default:     ring_nxt = ring;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            ring  <= '0;
            step  <= 1'b0;
        end else if (load) begin
            count <= '0;
            ring  <= SEED;
            step  <= 1'b0;
        end else begin
            count <= count + PRESC_BITS'(1);
            step  <= tick;
            if (tick) begin
                ring <= ring_nxt;
            end
        end
    end

endmodule

// File: tb/tb_ring_chaser.sv
// Directed bench for ring_chaser (WIDTH=6, PRESC_BITS=4) with a queue-based scoreboard.
// Expectations follow RING_CHASER_BOUNCE_EN the same way the design build does.
module tb_ring_chaser;

    localparam int W = 6;
    localparam int P = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         load = 1'b0;
    logic         fast = 1'b0;
    logic [1:0]   mode = 2'b00;
    logic [W-1:0] ring;
    logic         step;
    logic         dir;

    ring_chaser #(.WIDTH(W), .PRESC_BITS(P)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .fast  (fast),
        .mode  (mode),
        .ring  (ring),
        .step  (step),
        .dir   (dir)
    );

    always #5 clk = ~clk;

    // Packed observation: {ring, step, dir}
    logic [W+1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    logic [W-1:0] m_ring = '0;
    logic [P-1:0] m_cnt  = '0;
    logic         m_dir  = 1'b0;
    logic         m_step = 1'b0;

    function automatic logic [W-1:0] m_up(input logic [W-1:0] r);
        logic [W-1:0] n;
        for (int i = 0; i < W; i++) n[(i + 1) % W] = r[i];
        return n;
    endfunction

    function automatic logic [W-1:0] m_down(input logic [W-1:0] r);
        logic [W-1:0] n;
        for (int i = 0; i < W; i++) n[i] = r[(i + 1) % W];
        return n;
    endfunction

    task automatic check(input string tag, input logic [W+1:0] obs, input logic [W+1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic l, input logic f, input logic [1:0] md);
        logic tick;
        tick = f || (m_cnt == {P{1'b1}});
        if (l) begin
            m_ring = 6'b100000;
            m_cnt  = '0;
            m_dir  = 1'b0;
            m_step = 1'b0;
        end else begin
            m_cnt  = m_cnt + 1'b1;
            m_step = tick;
            if (tick) begin
                case (md)
                    2'b00: m_ring = m_up(m_ring);
                    2'b01: m_ring = m_down(m_ring);
                    2'b10: begin
`ifdef RING_CHASER_BOUNCE_EN
                        if (!m_dir) begin
                            if (m_ring[W-1]) begin m_dir = 1'b1; m_ring = m_down(m_ring); end
                            else m_ring = m_up(m_ring);
                        end else begin
                            if (m_ring[0]) begin m_dir = 1'b0; m_ring = m_up(m_ring); end
                            else m_ring = m_down(m_ring);
                        end
`else
                        m_ring = m_up(m_ring);
`endif
                    end
                    default: ;
                endcase
            end
        end
        exp_q.push_back({m_ring, m_step, m_dir});
    endtask

    // One clock: drive on the falling edge, score 1ns after the rising edge.
    task automatic cycle(input logic l, input logic f, input logic [1:0] md);
        logic [W+1:0] e;
        @(negedge clk);
        load = l;
        fast = f;
        mode = md;
        model_edge(l, f, md);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty observed=%0d expected=1", exp_q.size());
        end else begin
            e = exp_q.pop_front();
            check("sb", {ring, step, dir}, e);
        end
    endtask

    task automatic run(input int n, input logic l, input logic f, input logic [1:0] md);
        for (int i = 0; i < n; i++) cycle(l, f, md);
    endtask

    initial begin
        #1;
        check("reset_state", {ring, step, dir}, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // All-zero ring stays zero in every mode, step still strobes.
        run(3, 1'b0, 1'b1, 2'b00);
        check("zero_fast_up", {ring, step, dir}, {6'b000000, 1'b1, 1'b0});
        run(2, 1'b0, 1'b1, 2'b10);
        run(2, 1'b0, 1'b0, 2'b01);

        // Load seed
        cycle(1'b1, 1'b0, 2'b00);
        check("load_seed", {ring, step, dir}, {6'b100000, 1'b0, 1'b0});

        // Slow rotate up: first step 16 edges after load
        run(15, 1'b0, 1'b0, 2'b00);
        check("slow_before_tick", {ring, step}, {6'b100000, 1'b0});
        cycle(1'b0, 1'b0, 2'b00);
        check("slow_first_step", {ring, step}, {6'b000001, 1'b1});
        run(15, 1'b0, 1'b0, 2'b00);
        check("slow_step_low", {ring, step}, {6'b000001, 1'b0});
        cycle(1'b0, 1'b0, 2'b00);
        check("slow_second_step", {ring, step}, {6'b000010, 1'b1});

        // Fast rotate down
        cycle(1'b1, 1'b1, 2'b01);
        cycle(1'b0, 1'b1, 2'b01);
        check("fast_down_1", {ring, step}, {6'b010000, 1'b1});
        run(5, 1'b0, 1'b1, 2'b01);
        check("fast_down_6", {ring, step}, {6'b100000, 1'b1});

        // Bounce from load
        cycle(1'b1, 1'b1, 2'b10);
        cycle(1'b0, 1'b1, 2'b10);
`ifdef RING_CHASER_BOUNCE_EN
        check("bounce_first", {ring, step, dir}, {6'b010000, 1'b1, 1'b1});
        run(5, 1'b0, 1'b1, 2'b10);
        check("bounce_low_turn", {ring, step, dir}, {6'b000010, 1'b1, 1'b0});
        run(4, 1'b0, 1'b1, 2'b10);
        check("bounce_top", {ring, step, dir}, {6'b100000, 1'b1, 1'b0});
        cycle(1'b0, 1'b1, 2'b10);
        check("bounce_period", {ring, step, dir}, {6'b010000, 1'b1, 1'b1});
        // Leaving bounce retains dir
        cycle(1'b0, 1'b1, 2'b00);
        check("dir_retained", {ring, step, dir}, {6'b100000, 1'b1, 1'b1});
`else
        check("bounce_as_up", {ring, step, dir}, {6'b000001, 1'b1, 1'b0});
        run(10, 1'b0, 1'b1, 2'b10);
`endif

        // Load on a fast tick edge wins
        cycle(1'b1, 1'b1, 2'b00);
        check("load_over_fast", {ring, step, dir}, {6'b100000, 1'b0, 1'b0});
        // Load on a slow terminal-count edge wins
        run(15, 1'b0, 1'b0, 2'b00);
        cycle(1'b1, 1'b0, 2'b00);
        check("load_over_slow", {ring, step, dir}, {6'b100000, 1'b0, 1'b0});

        // Hold for 40 clocks: ring frozen, step at counts 15 and 31
        run(40, 1'b0, 1'b0, 2'b11);
        check("hold_frozen", {ring, step}, {6'b100000, 1'b0});

        // Fast to slow switch mid-count
        run(3, 1'b0, 1'b1, 2'b00);
        run(20, 1'b0, 1'b0, 2'b00);

        // Random mix
        for (int i = 0; i < 80; i++) begin
            cycle($urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0,
                  2'($urandom_range(0, 3)));
        end

        // Async reset between edges
        run(4, 1'b0, 1'b1, 2'b10);
        @(posedge clk);
        #3;
        model_edge(1'b0, fast, mode);
        void'(exp_q.pop_back());
        rst_n = 1'b0;
        #1;
        check("async_reset", {ring, step, dir}, '0);
        m_ring = '0;
        m_cnt  = '0;
        m_dir  = 1'b0;
        m_step = 1'b0;
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, 1'b0, 2'b10);
        run(20, 1'b0, 1'b0, 2'b10);
        run(12, 1'b0, 1'b1, 2'b10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #100000;
        checks++;
        errors++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
